// File: rtl/load_store_unit_pkg.sv
// Shared types and encodings for the RV32I load/store unit.
package load_store_unit_pkg;

  localparam int unsigned XLEN_W = 32;
  localparam int unsigned STRB_W = XLEN_W / 8;
  localparam int unsigned RD_W   = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] EXC_LMIS = 2'd0;
  localparam logic [1:0] EXC_SMIS = 2'd1;
  localparam logic [1:0] EXC_ILL  = 2'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  // Memory command held on the bus for the life of a request.
  typedef struct packed {
    logic              we;
    logic [XLEN_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [XLEN_W-1:0] wdata;
  } mem_cmd_t;

  // Load context needed to format the returning word.
  typedef struct packed {
    logic [1:0]      off;
    logic [2:0]      funct3;
    logic [RD_W-1:0] rd;
  } load_ctx_t;

endpackage

// File: rtl/load_store_unit_if.sv
// req/gnt/rvalid data-memory port; master = LSU, slave = memory.
interface load_store_unit_if
  import load_store_unit_pkg::*;
  ();

  logic              mem_req;
  logic              mem_we;
  logic [XLEN_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [XLEN_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational legality check, store lane/strobe steering and load extract/extend.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN_W-1:0] store_data,
  output logic              legal_c,
  output logic [1:0]        cause_c,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [XLEN_W-1:0] wdata_c,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [XLEN_W-1:0] ld_word,
  output logic [XLEN_W-1:0] ld_data_c
);

  logic              f3_ok;
  logic              aligned;
  logic [XLEN_W-1:0] shifted;

  // Size comes from funct3[1:0]; funct3[2] only selects unsigned loads.
  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b0;
    if (is_store) begin
      f3_ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      f3_ok = (funct3 == F3_LB)  || (funct3 == F3_LH) || (funct3 == F3_LW) ||
              (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_lo[0];
      default: aligned = (addr_lo == 2'b00);
    endcase
    legal_c = f3_ok & aligned;
    if (!f3_ok) begin
      cause_c = EXC_ILL;
    end else begin
      cause_c = is_store ? EXC_SMIS : EXC_LMIS;
    end
  end

  always_comb begin
    wdata_c = store_data;
    wstrb_c = '1;
    case (funct3[1:0])
      2'b00: begin
        wdata_c = {4{store_data[7:0]}};
        wstrb_c = STRB_W'(4'b0001 << addr_lo);
      end
      2'b01: begin
        wdata_c = {2{store_data[15:0]}};
        wstrb_c = STRB_W'(4'b0011 << addr_lo);
      end
      default: begin
        wdata_c = store_data;
        wstrb_c = '1;
      end
    endcase
  end

  always_comb begin
    shifted   = ld_word >> {ld_off, 3'b000};
    ld_data_c = shifted;
    case (ld_funct3)
      F3_LB:   ld_data_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   ld_data_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  ld_data_c = {24'd0, shifted[7:0]};
      F3_LHU:  ld_data_c = {16'd0, shifted[15:0]};
      default: ld_data_c = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: accepts one load/store per handshake, drives the data-memory
// port, and returns formatted load data or a misalignment/illegal exception.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              flush,
  load_store_unit_if.master mem,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              busy,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [XLEN-1:0]   exc_addr
);

  lsu_state_e state_q, state_d;

  mem_cmd_t          cmd_q, cmd_d;
  load_ctx_t         ctx_q, ctx_d;
  logic              req_q, req_d;
  logic              kill_q, kill_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              exc_valid_q, exc_valid_d;
  logic [1:0]        exc_cause_q, exc_cause_d;
  logic [XLEN-1:0]   exc_addr_q, exc_addr_d;

  logic              accept_c;
  logic              legal_c;
  logic [1:0]        cause_c;
  logic [STRB_W-1:0] wstrb_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   ld_data_c;
  logic              gnt_c;
  logic              load_done_c;

  load_store_unit_align u_align (
    .is_store   (ex_is_store),
    .funct3     (ex_funct3),
    .addr_lo    (ex_addr[1:0]),
    .store_data (ex_wdata),
    .legal_c    (legal_c),
    .cause_c    (cause_c),
    .wstrb_c    (wstrb_c),
    .wdata_c    (wdata_c),
    .ld_funct3  (ctx_q.funct3),
    .ld_off     (ctx_q.off),
    .ld_word    (mem.mem_rdata),
    .ld_data_c  (ld_data_c)
  );

  assign ex_ready    = (state_q == LSU_IDLE);
  assign accept_c    = ex_valid & ex_ready & ~flush;
  assign busy        = (state_q != LSU_IDLE) | (accept_c & legal_c);
  assign gnt_c       = (state_q == LSU_REQ) & mem.mem_gnt;
  // rvalid counts only once the request has been granted (same cycle or later).
  assign load_done_c = ~cmd_q.we & mem.mem_rvalid & (gnt_c | (state_q == LSU_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept_c && legal_c) state_d = LSU_REQ;
      LSU_REQ: begin
        if (mem.mem_gnt) begin
          if (cmd_q.we || mem.mem_rvalid) state_d = LSU_IDLE;
          else                            state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: if (mem.mem_rvalid) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    cmd_d       = cmd_q;
    ctx_d       = ctx_q;
    kill_d      = kill_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;

    if (accept_c) begin
      if (legal_c) begin
        req_d = 1'b1;
        cmd_d = '{we:    ex_is_store,
                  addr:  {ex_addr[XLEN-1:2], 2'b00},
                  wstrb: wstrb_c,
                  wdata: wdata_c};
        ctx_d = '{off: ex_addr[1:0], funct3: ex_funct3, rd: ex_rd};
      end else begin
        exc_valid_d = 1'b1;
        exc_cause_d = cause_c;
        exc_addr_d  = ex_addr;
      end
    end

    if (gnt_c) req_d = 1'b0;

    if (load_done_c && !kill_q && !flush) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = ctx_q.rd;
      wb_data_d  = ld_data_c;
    end

    // A flushed op still finishes its bus handshake but never writes back.
    if ((state_q != LSU_IDLE) && flush) kill_d = 1'b1;
    if (state_d == LSU_IDLE)            kill_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= 1'b0;
      cmd_q       <= '{we: 1'b0, addr: RESET_ADDR, wstrb: '0, wdata: '0};
      ctx_q       <= '0;
      kill_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= RESET_ADDR;
    end else begin
      req_q       <= req_d;
      cmd_q       <= cmd_d;
      ctx_q       <= ctx_d;
      kill_q      <= kill_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = cmd_q.we;
  assign mem.mem_addr  = cmd_q.addr;
  assign mem.mem_wstrb = cmd_q.wstrb;
  assign mem.mem_wdata = cmd_q.wdata;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign exc_valid     = exc_valid_q;
  assign exc_cause     = exc_cause_q;
  assign exc_addr      = exc_addr_q;

endmodule
